operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage between instruction decode and execute. Drives the read addresses of the 64-bit, 32-entry synchronous-read register file (X31 reads as zero, writes to X31 are dropped). Realigns instruction metadata with the one-cycle register-file read latency and supplies the write-bypass the register file lacks. Forwards from execute, stalls on load-use, and presents registered operands to execute over a valid/ready handshake.

## Interface
- W, 64, data width; must match register file
- ZR, 31, zero-register index
- TW, 32, width of opaque passthrough tag (PC/control bundle)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts this cycle
- in_rn, in_rm, in_rd  in  5  source and destination register indices
- in_use_rn, in_use_rm  in  1  source operand is actually read
- in_tag  in  TW  passthrough
- rf_ra1, rf_ra2  out  5  register file read addresses
- rf_rd1, rf_rd2  in  W  register file read data (one cycle after address)
- wb_we  in  1, wb_rd  in  5, wb_data  in  W  writeback; same signals drive the register file write port
- ex_we  in  1, ex_rd  in  5, ex_data  in  W  instruction currently in execute
- ex_data_ok  in  1  ex_data valid (0 while a load is outstanding)
- out_valid  out  1, out_ready  in  1  handshake to execute
- out_a, out_b  out  W, out_rd  out  5, out_tag  out  TW  registered operands and metadata

## Operation
- Two stages:
  - S1 holds metadata while the register file reads.
  - S2 is the output register.
- rf_ra1/rf_ra2 = in_rn/in_rm when in_ready && in_valid. Otherwise they hold S1's rn/rm, so the file re-reads every stalled cycle.
- Bypass registers byp1/byp2 are updated at every edge:
  - Set with wb_data when wb_we && wb_rd == rf_raN && rf_raN != ZR.
  - Cleared otherwise.
- S1 operand N is selected by priority:
  1. Source unused or index == ZR gives 0.
  2. ex_we && ex_rd == index gives ex_data.
  3. bypN valid gives bypN data.
  4. Otherwise rf_rdN.
- Hazard: S1 valid, operand used, index != ZR, ex_we && ex_rd == index && !ex_data_ok.
- S1 advances to S2 when S1 valid && !hazard && (!out_valid || out_ready).
- in_ready = rst && (!S1 valid || S1 advances).
- S2 clears out_valid on out_ready with nothing advancing.
- Outputs are stable while out_valid && !out_ready.

## Timing
- Reset (rst low at edge): S1 valid 0, byp valid 0, out_valid 0, out_a = out_b = 0, out_rd = ZR, out_tag = 0. in_ready = 0 while rst low.
- Latency: accept at edge t gives out_valid at edge t+2. Throughput is 1 per cycle with no hazard.
- Simultaneous writeback and read of the same register at one edge: the bypass supplies the new value.
- Simultaneous ex and wb match: ex wins, being younger.
- Hazard persists: S1 holds, in_ready = 0, and the register file re-reads.
- Hazard clears (ex_data_ok=1): advance the same cycle using ex_data.
- Backpressure (out_ready=0): S2 holds, then S1 holds, then in_ready drops. No instruction is lost or duplicated.
- rst low mid-operation discards S1 and S2 contents. Writes already issued to the register file are unaffected.

## Configuration
- OPF_EX_FWD_EN defined: execute forwarding as above.
- OPF_EX_FWD_EN undefined: no ex_data path. Any used operand with ex_we && ex_rd == index (index != ZR) is a hazard regardless of ex_data_ok. S1 stalls until the match disappears, and the value then arrives via bypass or register file.

## Test plan
- Reset, then X3=0x10 written via wb. Issue rn=3, rm=31, no ex match. Required: out_a=0x10, out_b=0, out_valid at accept+2.
- wb writes X5=0x999 on the same edge S1 samples ra1=5 (file holds 0x111). Required: out_a=0x999.
- ex_we=1, ex_rd=7, ex_data=0xABC, ex_data_ok=1; issue rn=7, wb writes X7=0x5 concurrently. With the macro: out_a=0xABC, no stall.
- ex_rd=7, ex_data_ok=0 for 3 cycles, then 1 with 0x42. Required: in_ready=0 for 3 cycles, then out_a=0x42. No duplicate output.
- Stream 4 instructions with out_ready=0 for 5 cycles. Required: outputs held stable. After release, 4 outputs in order with tags 1–4.
- Assert rst low with S1 and S2 full. Required: next cycle out_valid=0, out_a=0, out_rd=31. Rst high again: in_ready=1.

Source files
------------

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode, register-file, writeback, execute and output-handshake signals of the operand-fetch stage.
// master is the surrounding pipeline side; slave is operand_fetch itself.
interface operand_fetch_if #(
   parameter int W  = 64,
   parameter int TW = 32
);
   logic          in_valid;
   logic          in_ready;
   logic [4:0]    in_rn;
   logic [4:0]    in_rm;
   logic [4:0]    in_rd;
   logic          in_use_rn;
   logic          in_use_rm;
   logic [TW-1:0] in_tag;

   logic [4:0]    rf_ra1;
   logic [4:0]    rf_ra2;
   logic [W-1:0]  rf_rd1;
   logic [W-1:0]  rf_rd2;

   logic          wb_we;
   logic [4:0]    wb_rd;
   logic [W-1:0]  wb_data;

   logic          ex_we;
   logic [4:0]    ex_rd;
   logic [W-1:0]  ex_data;
   logic          ex_data_ok;

   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_a;
   logic [W-1:0]  out_b;
   logic [4:0]    out_rd;
   logic [TW-1:0] out_tag;

   modport master (
      output in_valid, in_rn, in_rm, in_rd, in_use_rn, in_use_rm, in_tag,
      input  in_ready,
      input  rf_ra1, rf_ra2,
      output rf_rd1, rf_rd2,
      output wb_we, wb_rd, wb_data,
      output ex_we, ex_rd, ex_data, ex_data_ok,
      input  out_valid, out_a, out_b, out_rd, out_tag,
      output out_ready
   );

   modport slave (
      input  in_valid, in_rn, in_rm, in_rd, in_use_rn, in_use_rm, in_tag,
      output in_ready,
      output rf_ra1, rf_ra2,
      input  rf_rd1, rf_rd2,
      input  wb_we, wb_rd, wb_data,
      input  ex_we, ex_rd, ex_data, ex_data_ok,
      output out_valid, out_a, out_b, out_rd, out_tag,
      input  out_ready
   );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: regfile read addressing, writeback bypass, load-use stall, execute forwarding when OPF_EX_FWD_EN is defined.
// Accept-to-out_valid one edge later (consumed at the second edge), 1/cycle; out_ready low holds S2, then S1, then drops in_ready.
module operand_fetch #(
   parameter int W  = 64,
   parameter int ZR = 31,
   parameter int TW = 32
) (
   input  logic           clk,
   input  logic           rst,
   operand_fetch_if.slave bus
);
   localparam logic [4:0] ZR_IDX = 5'(ZR);

   logic          s1_vld_q, s1_vld_d;
   logic [4:0]    s1_rn_q, s1_rn_d, s1_rm_q, s1_rm_d, s1_rd_q, s1_rd_d;
   logic          s1_use_rn_q, s1_use_rn_d, s1_use_rm_q, s1_use_rm_d;
   logic [TW-1:0] s1_tag_q, s1_tag_d;
   logic          byp1_vld_q, byp1_vld_d, byp2_vld_q, byp2_vld_d;
   logic [W-1:0]  byp1_dat_q, byp1_dat_d, byp2_dat_q, byp2_dat_d;
   logic          out_vld_q, out_vld_d;
   logic [W-1:0]  out_a_q, out_a_d, out_b_q, out_b_d;
   logic [4:0]    out_rd_q, out_rd_d;
   logic [TW-1:0] out_tag_q, out_tag_d;

   logic         accept, s1_adv, haz1, haz2, ex_hit1, ex_hit2;
   logic [4:0]   ra1, ra2;
   logic [W-1:0] op1, op2;

   // ex_hitN: the instruction in execute will write the register S1 operand N reads
   assign ex_hit1 = s1_use_rn_q && (s1_rn_q != ZR_IDX) && bus.ex_we && (bus.ex_rd == s1_rn_q);
   assign ex_hit2 = s1_use_rm_q && (s1_rm_q != ZR_IDX) && bus.ex_we && (bus.ex_rd == s1_rm_q);

`ifdef OPF_EX_FWD_EN
   assign haz1 = ex_hit1 && !bus.ex_data_ok;
   assign haz2 = ex_hit2 && !bus.ex_data_ok;
`else
   assign haz1 = ex_hit1;
   assign haz2 = ex_hit2;
   logic [W:0] unused_ex;
   assign unused_ex = {bus.ex_data_ok, bus.ex_data};
`endif

   assign s1_adv       = s1_vld_q && !haz1 && !haz2 && (!out_vld_q || bus.out_ready);
   assign bus.in_ready = rst && (!s1_vld_q || s1_adv);
   assign accept       = bus.in_ready && bus.in_valid;

   // A stalled S1 keeps re-reading its own sources so late writebacks are seen
   assign ra1 = accept ? bus.in_rn : s1_rn_q;
   assign ra2 = accept ? bus.in_rm : s1_rm_q;
   assign bus.rf_ra1 = ra1;
   assign bus.rf_ra2 = ra2;

   always_comb begin
      op1 = bus.rf_rd1;
      op2 = bus.rf_rd2;
      if (byp1_vld_q) op1 = byp1_dat_q;
      if (byp2_vld_q) op2 = byp2_dat_q;
`ifdef OPF_EX_FWD_EN
      if (ex_hit1) op1 = bus.ex_data;
      if (ex_hit2) op2 = bus.ex_data;
`endif
      if (!s1_use_rn_q || s1_rn_q == ZR_IDX) op1 = '0;
      if (!s1_use_rm_q || s1_rm_q == ZR_IDX) op2 = '0;
   end

   always_comb begin
      s1_vld_d    = s1_vld_q;
      s1_rn_d     = s1_rn_q;
      s1_rm_d     = s1_rm_q;
      s1_rd_d     = s1_rd_q;
      s1_use_rn_d = s1_use_rn_q;
      s1_use_rm_d = s1_use_rm_q;
      s1_tag_d    = s1_tag_q;
      if (accept) begin
         s1_vld_d    = 1'b1;
         s1_rn_d     = bus.in_rn;
         s1_rm_d     = bus.in_rm;
         s1_rd_d     = bus.in_rd;
         s1_use_rn_d = bus.in_use_rn;
         s1_use_rm_d = bus.in_use_rm;
         s1_tag_d    = bus.in_tag;
      end else if (s1_adv) begin
         s1_vld_d = 1'b0;
      end

      // The file returns the pre-write value when read and write coincide
      byp1_vld_d = bus.wb_we && (bus.wb_rd == ra1) && (ra1 != ZR_IDX);
      byp2_vld_d = bus.wb_we && (bus.wb_rd == ra2) && (ra2 != ZR_IDX);
      byp1_dat_d = bus.wb_data;
      byp2_dat_d = bus.wb_data;

      out_vld_d = out_vld_q;
      out_a_d   = out_a_q;
      out_b_d   = out_b_q;
      out_rd_d  = out_rd_q;
      out_tag_d = out_tag_q;
      if (s1_adv) begin
         out_vld_d = 1'b1;
         out_a_d   = op1;
         out_b_d   = op2;
         out_rd_d  = s1_rd_q;
         out_tag_d = s1_tag_q;
      end else if (bus.out_ready) begin
         out_vld_d = 1'b0;
      end

      if (!rst) begin
         s1_vld_d   = 1'b0;
         byp1_vld_d = 1'b0;
         byp2_vld_d = 1'b0;
         out_vld_d  = 1'b0;
         out_a_d    = '0;
         out_b_d    = '0;
         out_rd_d   = ZR_IDX;
         out_tag_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      s1_vld_q    <= s1_vld_d;
      s1_rn_q     <= s1_rn_d;
      s1_rm_q     <= s1_rm_d;
      s1_rd_q     <= s1_rd_d;
      s1_use_rn_q <= s1_use_rn_d;
      s1_use_rm_q <= s1_use_rm_d;
      s1_tag_q    <= s1_tag_d;
      byp1_vld_q  <= byp1_vld_d;
      byp2_vld_q  <= byp2_vld_d;
      byp1_dat_q  <= byp1_dat_d;
      byp2_dat_q  <= byp2_dat_d;
      out_vld_q   <= out_vld_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_rd_q    <= out_rd_d;
      out_tag_q   <= out_tag_d;
   end

   assign bus.out_valid = out_vld_q;
   assign bus.out_a     = out_a_q;
   assign bus.out_b     = out_b_q;
   assign bus.out_rd    = out_rd_q;
   assign bus.out_tag   = out_tag_q;
endmodule
